// File: rtl/cla_slice_sequencer_if.sv
// ALU-control side of the slice sequencer: start/ready/done handshake,
// operands in, result and flags out.
interface cla_slice_sequencer_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             op;
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic             ready;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             cOut;
   logic             overflow;
   logic             zero;

   modport master (
      output start, op, in1, in2,
      input  ready, done, result, cOut, overflow, zero
   );

   modport slave (
      input  start, op, in1, in2,
      output ready, done, result, cOut, overflow, zero
   );
endinterface

// File: rtl/cla_slice_sequencer.sv
// Time-multiplexes one external 4-bit carry-lookahead slice over a WIDTH-bit
// add/subtract, low nibble first, with the carry registered between slices.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready=1, waiting for start; result/flags hold last answer
// ST_RUN  | one nibble per cycle through the slice, idx = nibble
// ST_DONE | done=1 for one cycle, result and flags valid
module cla_slice_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic                        clk,
   input  logic                        rstN,
   cla_slice_sequencer_if.slave        bus,
   output logic [3:0]                  sliceA,
   output logic [3:0]                  sliceB,
   output logic                        sliceCin,
   input  logic [3:0]                  sliceSum,
   input  logic                        sliceCout
);

   localparam int NSLICE = WIDTH / 4;
   localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                  state_q;
   state_t                  state_d;

   // Nibble-indexed views so the slice mux and result write use idx directly.
   logic [NSLICE-1:0][3:0]  opa_q;
   logic [NSLICE-1:0][3:0]  opb_q;
   logic [NSLICE-1:0][3:0]  result_q;
   logic                    carry_q;
   logic [IDX_W-1:0]        idx_q;

   logic                    accept;
   logic                    last_slice;
   logic                    ready;
   logic                    done;

   assign accept     = (state_q == ST_IDLE) && bus.start;
   assign last_slice = (idx_q == IDX_LAST);

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ready   = 1'b0;
      done    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            ready = 1'b1;
            if (bus.start) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (last_slice) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Subtract is folded into the capture: B is inverted and the carry seeded
   // with 1, so the RUN loop is identical for both operations.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         opa_q    <= '0;
         opb_q    <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         idx_q    <= '0;
      end else if (accept) begin
         opa_q   <= bus.in1;
         opb_q   <= bus.in2 ^ {WIDTH{bus.op}};
         carry_q <= bus.op;
         idx_q   <= '0;
      end else if (state_q == ST_RUN) begin
         result_q[idx_q] <= sliceSum;
         carry_q         <= sliceCout;
         if (!last_slice) begin
            idx_q <= idx_q + 1'b1;
         end
      end
   end

   always_comb begin
      sliceA   = 4'h0;
      sliceB   = 4'h0;
      sliceCin = 1'b0;
      if (state_q == ST_RUN) begin
         sliceA   = opa_q[idx_q];
         sliceB   = opb_q[idx_q];
         sliceCin = carry_q;
      end
   end

   assign bus.ready    = ready;
   assign bus.done     = done;
   assign bus.result   = result_q;
   assign bus.cOut     = carry_q;
   // Uses the post-inversion B, so the same test covers add and subtract.
   assign bus.overflow = (opa_q[NSLICE-1][3] == opb_q[NSLICE-1][3]) &&
                         (result_q[NSLICE-1][3] != opa_q[NSLICE-1][3]);
   assign bus.zero     = (result_q == '0);

endmodule

// File: tb/tb_cla_slice_sequencer.sv
// Directed-vector and random bench for cla_slice_sequencer with a behavioural
// model of the external 4-bit slice.
module tb_cla_slice_sequencer;

   logic        clk;
   logic        rstN;
   logic [3:0]  slice_a;
   logic [3:0]  slice_b;
   logic        slice_cin;
   logic [3:0]  slice_sum;
   logic        slice_cout;

   int n_cmp = 0;
   int n_err = 0;

   cla_slice_sequencer_if #(.WIDTH(32)) bus ();

   cla_slice_sequencer #(.WIDTH(32)) dut (
      .clk       (clk),
      .rstN      (rstN),
      .bus       (bus),
      .sliceA    (slice_a),
      .sliceB    (slice_b),
      .sliceCin  (slice_cin),
      .sliceSum  (slice_sum),
      .sliceCout (slice_cout)
   );

   assign {slice_cout, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b} + {4'b0, slice_cin};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        c;
      logic        v;
      logic        z;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Starts at a negedge, leaves at the negedge of the first IDLE cycle after done.
   task automatic run_op(input string name, input logic o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er,
                         input logic ec, input logic ev, input logic ez);
      int wait_n = 0;
      int lat    = 1;
      while (!bus.ready && wait_n < 20) begin
         @(negedge clk);
         wait_n++;
      end
      chk({name, " ready"}, 32'(bus.ready), 32'd1);
      bus.start = 1'b1;
      bus.op    = o;
      bus.in1   = a;
      bus.in2   = b;
      @(negedge clk);
      bus.start = 1'b0;
      while (!bus.done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk({name, " latency"}, 32'(lat), 32'd9);
      chk({name, " result"}, bus.result, er);
      chk({name, " cOut"}, 32'(bus.cOut), 32'(ec));
      chk({name, " overflow"}, 32'(bus.overflow), 32'(ev));
      chk({name, " zero"}, 32'(bus.zero), 32'(ez));
      @(negedge clk);
      chk({name, " done_pulse"}, 32'({bus.done, bus.ready}), 32'b01);
   endtask

   task automatic start_op(input logic o, input logic [31:0] a, input logic [31:0] b);
      bus.start = 1'b1;
      bus.op    = o;
      bus.in1   = a;
      bus.in2   = b;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic check_reset_outputs(input string name);
      chk({name, " ready"}, 32'(bus.ready), 32'd1);
      chk({name, " done"}, 32'(bus.done), 32'd0);
      chk({name, " result"}, bus.result, 32'h0);
      chk({name, " cOut"}, 32'(bus.cOut), 32'd0);
      chk({name, " overflow"}, 32'(bus.overflow), 32'd0);
      chk({name, " zero"}, 32'(bus.zero), 32'd1);
      chk({name, " slice"}, 32'({slice_a, slice_b, slice_cin}), 32'd0);
   endtask

   initial begin
      int          dones;
      logic [31:0] ra;
      logic [31:0] rb;
      logic        ro;
      logic [32:0] wide;
      logic [31:0] mr;
      logic        mc;
      logic        mv;
      longint      sres;

      vecs[0]  = '{1'b0, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b1};
      vecs[1]  = '{1'b1, 32'h00000005, 32'h00000003, 32'h00000002, 1'b1, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0};
      vecs[3]  = '{1'b1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
      vecs[4]  = '{1'b0, 32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 32'h0000000F, 32'h00000001, 32'h00000010, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 32'h0FFFFFFF, 32'h00000001, 32'h10000000, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{1'b1, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{1'b1, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b1};
      vecs[10] = '{1'b1, 32'h00000000, 32'h80000000, 32'h80000000, 1'b0, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 1'b1};

      rstN      = 1'b0;
      bus.start = 1'b0;
      bus.op    = 1'b0;
      bus.in1   = '0;
      bus.in2   = '0;
      #3;
      check_reset_outputs("reset");
      @(negedge clk);
      @(negedge clk);
      rstN = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 12; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                vecs[i].res, vecs[i].c, vecs[i].v, vecs[i].z);
      end

      // Slice bus contents during a subtract.
      start_op(1'b1, 32'h00000005, 32'h00000003);
      chk("sub slice c1", 32'({slice_a, slice_b, slice_cin}), 32'({4'h5, 4'hC, 1'b1}));
      for (int c = 2; c <= 8; c++) begin
         @(negedge clk);
         chk($sformatf("sub slice c%0d", c), 32'({slice_a, slice_b}), 32'h0F);
      end
      @(negedge clk);
      chk("sub done", 32'(bus.done), 32'd1);
      chk("sub result", bus.result, 32'h00000002);
      chk("sub slice idle", 32'({slice_a, slice_b, slice_cin}), 32'd0);
      @(negedge clk);

      // Busy: start pulses in RUN and DONE, operands churning every cycle.
      start_op(1'b0, 32'h12345678, 32'h11111111);
      dones = 0;
      for (int c = 1; c <= 9; c++) begin
         if (bus.done) dones++;
         bus.in1   = $urandom;
         bus.in2   = $urandom;
         bus.op    = 1'b1;
         bus.start = (c == 3 || c == 9);
         @(negedge clk);
         bus.start = 1'b0;
      end
      chk("busy dones", 32'(dones), 32'd1);
      chk("busy result", bus.result, 32'h23456789);
      chk("busy ready", 32'(bus.ready), 32'd1);
      run_op("b2b", 1'b0, 32'h0000000F, 32'h00000001, 32'h00000010, 1'b0, 1'b0, 1'b0);
      dones = 0;
      for (int c = 0; c < 12; c++) begin
         if (bus.done || !bus.ready) dones++;
         @(negedge clk);
      end
      chk("no phantom op", 32'(dones), 32'd0);

      // Asynchronous reset mid-RUN.
      start_op(1'b0, 32'hFFFFFFFF, 32'h00000000);
      for (int c = 2; c <= 4; c++) @(negedge clk);
      chk("pre-rst run", 32'(bus.ready), 32'd0);
      #2;
      rstN = 1'b0;
      #1;
      check_reset_outputs("mid-rst");
      @(negedge clk);
      rstN = 1'b1;
      @(negedge clk);
      run_op("post-rst", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0);

      // Random operands against an arithmetic reference.
      for (int i = 0; i < 1000; i++) begin
         ra = $urandom;
         rb = $urandom;
         ro = 1'($urandom_range(1));
         if (ro) begin
            mr   = ra - rb;
            mc   = (ra >= rb);
            sres = longint'($signed(ra)) - longint'($signed(rb));
         end else begin
            wide = {1'b0, ra} + {1'b0, rb};
            mr   = wide[31:0];
            mc   = wide[32];
            sres = longint'($signed(ra)) + longint'($signed(rb));
         end
         mv = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
         run_op($sformatf("rnd%0d", i), ro, ra, rb, mr, mc, mv, (mr == 32'h0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/cla_slice_sequencer.md
# cla_slice_sequencer

Multi-cycle add/subtract controller that time-multiplexes one external 4-bit carry-lookahead adder slice to perform a full WIDTH-bit operation. The slice is processed least-significant nibble first, and the carry is registered between slices. The block sits in the 32-bit ALU as a low-area alternative to a fully unrolled adder chain. It presents a start/ready/done handshake to the ALU control and drives the slice's operand and carry-in pins directly.

## Interface

**Parameters**
- WIDTH, 32, operand width. Must be a multiple of 4. NSLICE = WIDTH/4.

**Ports**
- clk  in  1  clock, rising-edge.
- rstN  in  1  reset, asynchronous, active-low.
- start  in  1  request. Accepted only when ready=1.
- op  in  1  0 = add (in1+in2); 1 = subtract (in1-in2).
- in1  in  WIDTH  operand A, sampled on accept.
- in2  in  WIDTH  operand B, sampled on accept.
- ready  out  1  high in IDLE.
- done  out  1  one-cycle pulse; result and flags are valid.
- result  out  WIDTH  sum/difference.
- cOut  out  1  final carry. For subtract, 1 = no borrow.
- overflow  out  1  two's-complement signed overflow.
- zero  out  1  result == 0.
- sliceA  out  4  slice operand A.
- sliceB  out  4  slice operand B.
- sliceCin  out  1  slice carry-in.
- sliceSum  in  4  slice sum, combinational from sliceA/sliceB/sliceCin.
- sliceCout  in  1  slice carry-out, combinational.

## Operation

**States**
- IDLE: ready=1.
  - On start=1, capture opA<=in1, opB<=in2 XOR {WIDTH{op}}, carry<=op, idx<=0, then go to RUN.
  - start=0 stays in IDLE.
- RUN: ready=0.
  - Drive sliceA=opA[4*idx+3:4*idx], sliceB=opB[4*idx+3:4*idx], sliceCin=carry.
  - Each edge: result[4*idx+3:4*idx]<=sliceSum, carry<=sliceCout, idx<=idx+1.
  - When idx==NSLICE-1, go to DONE instead of incrementing.
- DONE: done=1 for exactly this cycle; ready=0. Next edge goes to IDLE unconditionally.

**Rules**
- Outside RUN, sliceA=0, sliceB=0, sliceCin=0.
- start is ignored outside IDLE. Captured operands are unaffected by in1/in2/op changes after accept.
- cOut=carry (the slice carry after the last slice), registered.
- overflow = (opA[WIDTH-1]==opB[WIDTH-1]) && (result[WIDTH-1]!=opA[WIDTH-1]). It uses the post-inversion opB.
- zero = (result==0).
- Flags are combinational from registers and guaranteed only while done=1. result, cOut, overflow and zero hold their values from done until the next accept.
- During RUN, result contains a mix of old and new nibbles. Consumers must not sample it then.
- idx width is clog2(NSLICE). idx never wraps past NSLICE-1.

**Reset**
- Asynchronous and immediate, including mid-RUN.
- State goes to IDLE and idx, carry, opA, opB, result all go to 0.
- Resulting outputs: ready=1, done=0, result=0, cOut=0, overflow=0, zero=1, slice outputs 0.

## Timing

- Accept edge E0 (start=1 and ready=1).
- RUN occupies the NSLICE cycles following E0; slice k is evaluated in cycle k+1.
- done is high in cycle NSLICE+1 after E0, i.e. cycle 9 for WIDTH=32.
- ready rises in the following cycle. The earliest next accept is at edge E0+NSLICE+2, giving 10 cycles per operation for WIDTH=32.
- Slice path: registered opA/opB/carry → slice → result/carry register. This must close in one clk period.
- No combinational path from start to any output except via state.

## Test plan

- **Add with carry:** add 0x00000001 + 0xFFFFFFFF → result=0x00000000, cOut=1, zero=1, overflow=0. done pulses exactly 9 cycles after the accept edge, for one cycle.
- **Subtract, slice bus check:** sub 0x00000005 - 0x00000003 → result=0x00000002, cOut=1, overflow=0, zero=0. In RUN cycle 1, check sliceA=0x5, sliceB=0xC, sliceCin=1. In cycles 2-8, check sliceA=0x0 and sliceB=0xF.
- **Signed overflow:** add 0x7FFFFFFF + 0x00000001 → 0x80000000, overflow=1, cOut=0. Then sub 0x80000000 - 0x00000001 → 0x7FFFFFFF, overflow=1, cOut=1.
- **Busy and operand isolation:** start an add of 0x12345678 + 0x11111111. Then pulse start with op=1 and different operands in RUN cycles 3 and 9 (DONE), and change in1/in2 every cycle. Expected: only one done, result=0x23456789, no second operation starts. Afterwards, a back-to-back start accepted in the first IDLE cycle completes normally.
- **Reset mid-operation:** assert rstN=0 asynchronously (between edges) during RUN cycle 4. Expected: ready=1, done=0, result=0, and slice outputs=0 immediately. After release, an add 0xFFFFFFFF + 0xFFFFFFFF → 0xFFFFFFFE, cOut=1, overflow=0, with full 9-cycle latency.
- **Exhaustive nibble carry chain:** for 1000 random operand pairs and random op, compare result/cOut/overflow/zero against a reference model. Include 0x0000000F+0x00000001 and 0x0FFFFFFF+0x00000001 to exercise the carry ripple across every slice boundary.
